coh_noc_vc_buffer: RTL and testbench

Parametrised multi-virtual-channel input buffer with credit-based flow control on both sides. It sits at every router/NI ingress port. It stores incoming flits in per-VC FIFOs and returns one upstream credit per dequeued flit. It tracks downstream credits per VC and arbitrates among eligible VCs to drive one registered output flit per cycle. It generalises the fixed 4-VC / 16-deep buffering to arbitrary VC count, depth, flit width, credit budget and arbitration mode.

---
 rtl/coh_noc_vc_buffer.sv | 183 ++++++++++++++++++
 tb/tb_coh_noc_vc_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/coh_noc_vc_buffer.sv
// Multi-VC ingress buffer: per-VC FIFOs with upstream credit return, downstream
// credit tracking and round-robin / fixed-priority selection of one output flit.
module coh_noc_vc_buffer #(
  parameter int NUM_VC       = 4,
  parameter int DEPTH        = 16,
  parameter int FLIT_W       = 128,
  parameter int DOWN_CREDITS = 16,
  parameter int ARB_MODE     = 0,
  parameter int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [VC_W-1:0]                      in_vc,
  input  logic [FLIT_W-1:0]                    in_flit,
  output logic [NUM_VC-1:0]                    up_credit_o,
  output logic                                 out_valid,
  output logic [VC_W-1:0]                      out_vc,
  output logic [FLIT_W-1:0]                    out_flit,
  input  logic [NUM_VC-1:0]                    down_credit_i,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0]  occupancy_o,
  output logic                                 err_overflow_o,
  output logic                                 err_credit_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int CRED_W = $clog2(DOWN_CREDITS + 1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DOWN_CREDITS);

  logic [FLIT_W-1:0] mem_q [NUM_VC][DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [OCC_W-1:0]  occ_q    [NUM_VC];
  logic [OCC_W-1:0]  occ_d    [NUM_VC];
  logic [CRED_W-1:0] cred_q   [NUM_VC];
  logic [CRED_W-1:0] cred_d   [NUM_VC];

  logic [VC_W-1:0]   rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [VC_W-1:0]   out_vc_q, out_vc_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic [NUM_VC-1:0] up_credit_q, up_credit_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_cred_q, err_cred_d;

  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] push_vec;
  logic [NUM_VC-1:0] pop_vec;
  logic              in_vc_hit;
  logic              grant_valid;
  logic [VC_W-1:0]   grant_vc;

  function automatic logic [VC_W-1:0] vc_add(input logic [VC_W-1:0] base, input int k);
    int sum;
    sum = 32'(base) + k;
    if (sum >= NUM_VC) sum = sum - NUM_VC;
    return VC_W'(sum);
  endfunction

  // Eligibility uses registered occupancy, so a flit is never bypassed to the output.
  always_comb begin
    eligible = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      eligible[v] = (occ_q[v] != '0) && (cred_q[v] != '0);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = '0;
    if (ARB_MODE == 1) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (eligible[v]) begin
          grant_valid = 1'b1;
          grant_vc    = VC_W'(v);
        end
      end
    end else begin
      // Scan backwards so the candidate closest to rr_q is the one that sticks.
      for (int k = NUM_VC - 1; k >= 0; k--) begin
        if (eligible[vc_add(rr_q, k)]) begin
          grant_valid = 1'b1;
          grant_vc    = vc_add(rr_q, k);
        end
      end
    end
  end

  always_comb begin
    push_vec   = '0;
    pop_vec    = '0;
    in_vc_hit  = 1'b0;
    err_ovf_d  = err_ovf_q;
    err_cred_d = err_cred_q;
    for (int v = 0; v < NUM_VC; v++) begin
      pop_vec[v] = grant_valid && (grant_vc == VC_W'(v));
      if (in_valid && (in_vc == VC_W'(v))) begin
        in_vc_hit = 1'b1;
        if (occ_q[v] == OCC_FULL) err_ovf_d = 1'b1;
        else                      push_vec[v] = 1'b1;
      end
    end
    if (in_valid && !in_vc_hit) err_ovf_d = 1'b1;

    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(push_vec[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop_vec[v]);
      occ_d[v]    = occ_q[v] + OCC_W'(push_vec[v]) - OCC_W'(pop_vec[v]);
      cred_d[v]   = cred_q[v];
      if (pop_vec[v] && !down_credit_i[v]) begin
        cred_d[v] = cred_q[v] - CRED_W'(1);
      end else if (down_credit_i[v] && !pop_vec[v]) begin
        if (cred_q[v] == CRED_MAX) err_cred_d = 1'b1;
        else                       cred_d[v]  = cred_q[v] + CRED_W'(1);
      end
    end

    out_valid_d = grant_valid;
    out_vc_d    = grant_valid ? grant_vc : out_vc_q;
    out_flit_d  = grant_valid ? mem_q[grant_vc][rd_ptr_q[grant_vc]] : out_flit_q;
    up_credit_d = pop_vec;
    rr_d        = grant_valid ? vc_add(grant_vc, 1) : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        occ_q[v]    <= '0;
        cred_q[v]   <= CRED_MAX;
      end
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_flit_q  <= '0;
      up_credit_q <= '0;
      err_ovf_q   <= 1'b0;
      err_cred_q  <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        occ_q[v]    <= occ_d[v];
        cred_q[v]   <= cred_d[v];
      end
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      out_flit_q  <= out_flit_d;
      up_credit_q <= up_credit_d;
      err_ovf_q   <= err_ovf_d;
      err_cred_q  <= err_cred_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vec[v]) mem_q[v][wr_ptr_q[v]] <= in_flit;
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      occupancy_o[v*OCC_W +: OCC_W] = occ_q[v];
    end
  end

  assign up_credit_o    = up_credit_q;
  assign out_valid      = out_valid_q;
  assign out_vc         = out_vc_q;
  assign out_flit       = out_flit_q;
  assign err_overflow_o = err_ovf_q;
  assign err_credit_o   = err_cred_q;

endmodule

// File: tb/tb_coh_noc_vc_buffer.sv
// Bench for coh_noc_vc_buffer: a round-robin and a fixed-priority instance share
// the input stream and are compared every cycle against a queue-based model.
module tb_coh_noc_vc_buffer;

  localparam int NV = 3;
  localparam int DP = 4;
  localparam int FW = 16;
  localparam int DC = 3;
  localparam int VW = 2;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_vc = '0;
  logic [FW-1:0] in_flit = '0;
  logic [NV-1:0] dcr [2];

  logic [NV-1:0]    upc [2];
  logic             ov  [2];
  logic [VW-1:0]    ovc [2];
  logic [FW-1:0]    ofl [2];
  logic [NV*OW-1:0] occ [2];
  logic             eo  [2];
  logic             ec  [2];

  // Model state: one set per instance (0 = round-robin, 1 = fixed priority).
  logic [FW-1:0] mq [2][NV][$];
  int            mcred [2][NV];
  int            mnext [2];
  bit            ev    [2];
  int            evc   [2];
  logic [FW-1:0] eflit [2];
  logic [NV-1:0] eupc  [2];
  bit            eovf  [2];
  bit            ecred [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  coh_noc_vc_buffer #(.NUM_VC(NV), .DEPTH(DP), .FLIT_W(FW), .DOWN_CREDITS(DC), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .up_credit_o(upc[0]), .out_valid(ov[0]), .out_vc(ovc[0]), .out_flit(ofl[0]),
    .down_credit_i(dcr[0]), .occupancy_o(occ[0]), .err_overflow_o(eo[0]), .err_credit_o(ec[0])
  );

  coh_noc_vc_buffer #(.NUM_VC(NV), .DEPTH(DP), .FLIT_W(FW), .DOWN_CREDITS(DC), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .up_credit_o(upc[1]), .out_valid(ov[1]), .out_vc(ovc[1]), .out_flit(ofl[1]),
    .down_credit_i(dcr[1]), .occupancy_o(occ[1]), .err_overflow_o(eo[1]), .err_credit_o(ec[1])
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    for (int c = 0; c < NV; c++) begin
      mq[i][c].delete();
      mcred[i][c] = DC;
    end
    mnext[i] = 0;
    ev[i]    = 1'b0;
    evc[i]   = 0;
    eflit[i] = '0;
    eupc[i]  = '0;
    eovf[i]  = 1'b0;
    ecred[i] = 1'b0;
  endtask

  // One clock edge of the reference behaviour, decided from the pre-edge state.
  task automatic model_step(input int i, input bit v, input int vc, input logic [FW-1:0] f,
                            input logic [NV-1:0] d);
    int g;
    bit full;
    g = -1;
    if (i == 0) begin
      for (int k = 0; k < NV; k++) begin
        if (g < 0 && mq[i][(mnext[i] + k) % NV].size() > 0 && mcred[i][(mnext[i] + k) % NV] > 0)
          g = (mnext[i] + k) % NV;
      end
    end else begin
      for (int c = NV - 1; c >= 0; c--) begin
        if (g < 0 && mq[i][c].size() > 0 && mcred[i][c] > 0) g = c;
      end
    end
    full = (v && vc < NV) ? (mq[i][vc].size() == DP) : 1'b0;
    ev[i]   = 1'b0;
    eupc[i] = '0;
    if (g >= 0) begin
      ev[i]       = 1'b1;
      evc[i]      = g;
      eflit[i]    = mq[i][g].pop_front();
      eupc[i][g]  = 1'b1;
      mcred[i][g] = mcred[i][g] - 1;
      mnext[i]    = (g + 1) % NV;
    end
    for (int c = 0; c < NV; c++) begin
      if (d[c]) begin
        if (mcred[i][c] == DC) ecred[i] = 1'b1;
        else                   mcred[i][c] = mcred[i][c] + 1;
      end
    end
    if (v) begin
      if (vc >= NV || full) eovf[i] = 1'b1;
      else                  mq[i][vc].push_back(f);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      logic [NV*OW-1:0] exp_occ;
      exp_occ = '0;
      for (int c = 0; c < NV; c++) exp_occ[c*OW +: OW] = OW'(mq[i][c].size());
      check_val($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(ev[i]));
      check_val($sformatf("out_vc[%0d]", i), 64'(ovc[i]), 64'(evc[i]));
      check_val($sformatf("out_flit[%0d]", i), 64'(ofl[i]), 64'(eflit[i]));
      check_val($sformatf("up_credit[%0d]", i), 64'(upc[i]), 64'(eupc[i]));
      check_val($sformatf("occupancy[%0d]", i), 64'(occ[i]), 64'(exp_occ));
      check_val($sformatf("err_overflow[%0d]", i), 64'(eo[i]), 64'(eovf[i]));
      check_val($sformatf("err_credit[%0d]", i), 64'(ec[i]), 64'(ecred[i]));
    end
  endtask

  task automatic applyStimulus(input bit v, input int vc, input logic [FW-1:0] f,
                               input logic [NV-1:0] d0, input logic [NV-1:0] d1);
    in_valid = v;
    in_vc    = VW'(vc);
    in_flit  = f;
    dcr[0]   = d0;
    dcr[1]   = d1;
    model_step(0, v, vc, f, d0);
    model_step(1, v, vc, f, d1);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, '0, '0, '0);
  endtask

  // Reset lands between clock edges; outputs must clear before any edge arrives.
  task automatic async_reset();
    in_valid = 1'b0;
    dcr[0]   = '0;
    dcr[1]   = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    dcr[0] = '0;
    dcr[1] = '0;
    async_reset();

    applyStimulus(1'b1, 2, 16'h00A1, '0, '0);
    applyStimulus(1'b1, 2, 16'h00A2, '0, '0);
    applyStimulus(1'b1, 2, 16'h00A3, '0, '0);
    idle(4);

    for (int c = 0; c < NV; c++)
      for (int k = 0; k < DC; k++) applyStimulus(1'b1, c, FW'(16'h1000 + c * 16 + k), '0, '0);
    idle(4);

    for (int c = 0; c < NV; c++) applyStimulus(1'b1, c, FW'(16'h2000 + c), '0, '0);
    applyStimulus(1'b0, 0, '0, 3'b111, 3'b111);
    idle(4);

    applyStimulus(1'b1, 1, 16'h3001, '0, '0);
    applyStimulus(1'b1, 1, 16'h3002, '0, '0);
    applyStimulus(1'b1, 1, 16'h3003, '0, '0);
    idle(2);
    applyStimulus(1'b0, 0, '0, 3'b010, 3'b010);
    applyStimulus(1'b0, 0, '0, 3'b010, 3'b010);
    idle(4);

    for (int k = 0; k <= DP; k++) applyStimulus(1'b1, 0, FW'(16'h4000 + k), '0, '0);
    applyStimulus(1'b1, 2, 16'h4100, '0, '0);
    idle(2);
    async_reset();
    idle(3);

    applyStimulus(1'b1, 3, 16'h5000, '0, '0);
    idle(2);
    async_reset();

    applyStimulus(1'b0, 0, '0, 3'b010, 3'b010);
    idle(2);
    async_reset();

    for (int n = 0; n < 600; n++) begin
      logic [NV-1:0] d0;
      logic [NV-1:0] d1;
      int            r;
      for (int c = 0; c < NV; c++) begin
        d0[c] = (mcred[0][c] < DC) && ($urandom_range(0, 2) == 0);
        d1[c] = (mcred[1][c] < DC) && ($urandom_range(0, 2) == 0);
      end
      r = $urandom_range(0, 31);
      applyStimulus($urandom_range(0, 3) != 0, (r == 31) ? 3 : r % NV, FW'($urandom), d0, d1);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
